// File: rtl/minos_pkg.sv
// Shared definitions for the MinOS TX path: scheduler state encoding
// and the chunk type codes carried in tx_chunk_type.
package minos_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } sched_state_e;

  localparam logic [7:0] CHUNK_LEDS     = 8'd2;
  localparam logic [7:0] CHUNK_BUTTONS  = 8'd3;
  localparam logic [7:0] CHUNK_SWITCHES = 8'd4;
  localparam logic [7:0] CHUNK_TEXT     = 8'd5;
  localparam logic [7:0] CHUNK_DISPLAY  = 8'd6;

endpackage

// File: rtl/minos_rr_arbiter.sv
// Combinational channel arbiter: round-robin from a pointer, or fixed
// priority (lowest index) when RR_MODE is 0.
module minos_rr_arbiter #(
  parameter int CH_N     = 4,
  parameter int CH_IDX_W = 4,
  parameter int RR_MODE  = 1
) (
  input  logic [CH_N-1:0]     requests,
  input  logic [CH_IDX_W-1:0] pointer,
  output logic [CH_IDX_W-1:0] grant,
  output logic                grant_valid
);

  logic [CH_IDX_W-1:0] low_idx;
  logic [CH_IDX_W-1:0] upper_idx;
  logic                upper_any;

  // Lowest requester overall, and lowest requester at/after the pointer;
  // the latter wins in round-robin mode, the former covers the wrap.
  always_comb begin
    low_idx     = '0;
    upper_idx   = '0;
    upper_any   = 1'b0;
    grant_valid = |requests;
    for (int i = CH_N - 1; i >= 0; i--) begin
      if (requests[i]) begin
        low_idx = CH_IDX_W'(i);
        if ((RR_MODE != 0) && (i >= int'(pointer))) begin
          upper_idx = CH_IDX_W'(i);
          upper_any = 1'b1;
        end
      end
    end
    grant = upper_any ? upper_idx : low_idx;
  end

endmodule

// File: rtl/minos_tx_scheduler.sv
// MinOS TX scheduler: picks one requesting virtual-interface channel,
// latches its chunk for the typed UART chunker, acks the channel, and
// waits for the chunker (optionally bounded by a watchdog).
module minos_tx_scheduler
  import minos_pkg::*;
#(
  parameter int CH_N           = 4,
  parameter int CONTENT_BYTES  = 33,
  parameter int INDEX_W        = 8,
  parameter int CH_IDX_W       = 4,
  parameter int RR_MODE        = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                            CLK,
  input  logic                            reset,
  input  logic [CH_N-1:0]                 ch_should_update,
  input  logic [CH_N*8-1:0]               ch_chunk_type,
  input  logic [CH_N*INDEX_W-1:0]         ch_chunk_size,
  input  logic [CH_N*CONTENT_BYTES*8-1:0] ch_chunk_bytes,
  output logic [CH_N-1:0]                 ch_ack,
  output logic                            tx_is_chunk_ready,
  output logic [7:0]                      tx_chunk_type,
  output logic [INDEX_W-1:0]              tx_chunk_byte_size,
  output logic [CONTENT_BYTES*8-1:0]      tx_chunk_bytes,
  input  logic                            tx_is_chunker_done,
  output logic                            busy,
  output logic [CH_IDX_W-1:0]             active_channel,
  output logic                            err_oversize,
  output logic                            err_timeout,
  input  logic                            err_clear
);

  localparam int PAY_W = CONTENT_BYTES * 8;

  sched_state_e          state_q, state_d;
  logic [CH_IDX_W-1:0]   ptr_q, ptr_d, chan_q, chan_d;
  logic [7:0]            type_q, type_d;
  logic [INDEX_W-1:0]    size_q, size_d;
  logic [PAY_W-1:0]      bytes_q, bytes_d;
  logic                  err_ov_q, err_ov_d, err_to_q, err_to_d;
  logic [31:0]           cnt_q, cnt_d;

  logic [CH_IDX_W-1:0]   gnt;
  logic                  gnt_valid;
  logic [7:0]            sel_type;
  logic [INDEX_W-1:0]    sel_size;
  logic [PAY_W-1:0]      sel_bytes;
  logic                  ov_set, to_set;

  minos_rr_arbiter #(
    .CH_N    (CH_N),
    .CH_IDX_W(CH_IDX_W),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .requests   (ch_should_update),
    .pointer    (ptr_q),
    .grant      (gnt),
    .grant_valid(gnt_valid)
  );

  // Steer the granted channel's type/size/payload out of the flat buses.
  always_comb begin
    sel_type  = '0;
    sel_size  = '0;
    sel_bytes = '0;
    for (int i = 0; i < CH_N; i++) begin
      if (gnt == CH_IDX_W'(i)) begin
        sel_type  = ch_chunk_type[i*8 +: 8];
        sel_size  = ch_chunk_size[i*INDEX_W +: INDEX_W];
        sel_bytes = ch_chunk_bytes[i*PAY_W +: PAY_W];
      end
    end
  end

  // Next-state logic: grant in IDLE, one-cycle LOAD, WAIT for done or watchdog.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    chan_d  = chan_q;
    type_d  = type_q;
    size_d  = size_q;
    bytes_d = bytes_q;
    cnt_d   = cnt_q;
    ov_set  = 1'b0;
    to_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          type_d  = sel_type;
          bytes_d = sel_bytes;
          chan_d  = gnt;
          if (sel_size > INDEX_W'(CONTENT_BYTES)) begin
            size_d = INDEX_W'(CONTENT_BYTES);
            ov_set = 1'b1;
          end else begin
            size_d = sel_size;
          end
          if (RR_MODE != 0) begin
            ptr_d = (gnt == CH_IDX_W'(CH_N - 1)) ? '0 : gnt + 1'b1;
          end
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = (size_q != '0) ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        if (tx_is_chunker_done) begin
          state_d = ST_IDLE;
        end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1))) begin
          to_set  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A set event in the same cycle as err_clear keeps the flag high.
    err_ov_d = ov_set | (err_ov_q & ~err_clear);
    err_to_d = to_set | (err_to_q & ~err_clear);
  end

  // State and datapath registers with immediate reset.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      chan_q   <= '0;
      type_q   <= '0;
      size_q   <= '0;
      bytes_q  <= '0;
      err_ov_q <= 1'b0;
      err_to_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      chan_q   <= chan_d;
      type_q   <= type_d;
      size_q   <= size_d;
      bytes_q  <= bytes_d;
      err_ov_q <= err_ov_d;
      err_to_q <= err_to_d;
      cnt_q    <= cnt_d;
    end
  end

  for (genvar gi = 0; gi < CH_N; gi++) begin : g_ack
    assign ch_ack[gi] = (state_q == ST_LOAD) && (chan_q == CH_IDX_W'(gi));
  end

  assign tx_is_chunk_ready  = (state_q == ST_LOAD) && (size_q != '0);
  assign tx_chunk_type      = type_q;
  assign tx_chunk_byte_size = size_q;
  assign tx_chunk_bytes     = bytes_q;
  assign busy               = (state_q != ST_IDLE);
  assign active_channel     = chan_q;
  assign err_oversize       = err_ov_q;
  assign err_timeout        = err_to_q;

endmodule
